// File: rtl/dmi_jtag_dr.sv
// dmi_jtag_dr: TCK-domain data-register stage for the RISC-V debug transport
// module. It implements the DTMCS and DMI data registers behind the JTAG TAP.
// Each completed DMI scan becomes a valid/ready request toward the DMI
// clock-domain crossing, and the response is folded back into the DMI
// register.
//
// Optional feature macro: DMI_HARDRESET_EN
//   defined   : writing dtmcs.dmihardreset aborts any transaction and pulses
//               dmi_clear_o for one cycle
//   undefined : dtmcs.dmihardreset is ignored and dmi_clear_o is tied low
//
// Parameters:
//   AddrWidth  - DMI address width (DMI DR is AddrWidth+34 bits)
//   IdleCycles - reported in dtmcs.idle
//   DmiVersion - reported in dtmcs.version
//
// Ports:
//   tck_i, trst_ni                 - TCK clock, synchronous active-low reset
//   capture_i, shift_i, update_i   - TAP DR strobes (mutually exclusive)
//   tdi_i                          - serial data in
//   dtmcs_select_i, dtmcs_tdo_o    - DTMCS instruction select / serial out
//   dmi_select_i, dmi_tdo_o        - DMIACCESS instruction select / serial out
//   dmi_req_*                      - request channel (valid/ready, addr, op, data)
//   dmi_resp_*                     - response channel (valid/ready, data, resp)
//   dmi_clear_o                    - one-cycle CDC flush pulse on hard reset
module dmi_jtag_dr #(
    parameter int unsigned AddrWidth  = 7,
    parameter logic [2:0]  IdleCycles = 3'd1,
    parameter logic [3:0]  DmiVersion = 4'd1
) (
    input  logic                 tck_i,
    input  logic                 trst_ni,
    input  logic                 capture_i,
    input  logic                 shift_i,
    input  logic                 update_i,
    input  logic                 tdi_i,
    input  logic                 dtmcs_select_i,
    output logic                 dtmcs_tdo_o,
    input  logic                 dmi_select_i,
    output logic                 dmi_tdo_o,
    output logic                 dmi_req_valid_o,
    input  logic                 dmi_req_ready_i,
    output logic [AddrWidth-1:0] dmi_req_addr_o,
    output logic [1:0]           dmi_req_op_o,
    output logic [31:0]          dmi_req_data_o,
    input  logic                 dmi_resp_valid_i,
    output logic                 dmi_resp_ready_o,
    input  logic [31:0]          dmi_resp_data_i,
    input  logic [1:0]           dmi_resp_resp_i,
    output logic                 dmi_clear_o
);

    localparam int unsigned DrWidth = AddrWidth + 34;
    localparam logic [5:0]  Abits   = 6'(AddrWidth);

    typedef enum logic [1:0] {
        Idle = 2'd0,
        Req  = 2'd1,
        Wait = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [31:0]          dtmcs_q, dtmcs_d;
    logic [DrWidth-1:0]   dr_q, dr_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [31:0]          data_q, data_d;
    logic [1:0]           op_q, op_d;
    logic [1:0]           error_q, error_d;

`ifdef DMI_HARDRESET_EN
    logic                 clear_q, clear_d;
    assign dmi_clear_o = clear_q;
`else
    assign dmi_clear_o = 1'b0;
`endif

    assign dtmcs_tdo_o      = dtmcs_q[0];
    assign dmi_tdo_o        = dr_q[0];
    assign dmi_req_valid_o  = (state_q == Req);
    assign dmi_resp_ready_o = (state_q == Wait);
    assign dmi_req_addr_o   = addr_q;
    assign dmi_req_op_o     = op_q;
    assign dmi_req_data_o   = data_q;

    // Next-state logic. The handshake FSM is evaluated first so that the
    // DTMCS error-clearing actions and the DMI capture (which reports busy
    // from the pre-edge state) take precedence over a same-edge response.
    always_comb begin
        state_d = state_q;
        dtmcs_d = dtmcs_q;
        dr_d    = dr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        op_d    = op_q;
        error_d = error_q;
`ifdef DMI_HARDRESET_EN
        clear_d = 1'b0;
`endif

        unique case (state_q)
            Idle: ;
            Req: begin
                if (dmi_req_ready_i) begin
                    state_d = Wait;
                end
            end
            Wait: begin
                if (dmi_resp_valid_i) begin
                    if (op_q == 2'd1) begin
                        data_d = dmi_resp_data_i;
                    end
                    // A reserved response code of 1 is reported as failed.
                    if (dmi_resp_resp_i != 2'd0) begin
                        error_d = (dmi_resp_resp_i == 2'd1) ? 2'd2 : dmi_resp_resp_i;
                    end
                    state_d = Idle;
                end
            end
            default: state_d = Idle;
        endcase

        if (dtmcs_select_i) begin
            if (capture_i) begin
                dtmcs_d = {14'd0, 1'b0, 1'b0, 1'b0, IdleCycles, error_q, Abits, DmiVersion};
            end else if (shift_i) begin
                dtmcs_d = {tdi_i, dtmcs_q[31:1]};
            end else if (update_i) begin
                // dmireset only clears the sticky error; an in-flight
                // transaction is left to complete.
                if (dtmcs_q[16]) begin
                    error_d = 2'd0;
                end
`ifdef DMI_HARDRESET_EN
                if (dtmcs_q[17]) begin
                    state_d = Idle;
                    error_d = 2'd0;
                    addr_d  = '0;
                    data_d  = '0;
                    op_d    = '0;
                    clear_d = 1'b1;
                end
`endif
            end
        end

        if (dmi_select_i) begin
            if (capture_i) begin
                dr_d = {addr_q, data_q, error_q};
                // Scanning while a transaction is outstanding is a busy
                // violation and makes the error sticky.
                if (state_q != Idle) begin
                    dr_d[1:0] = 2'd3;
                    error_d   = 2'd3;
                end
            end else if (shift_i) begin
                dr_d = {tdi_i, dr_q[DrWidth-1:1]};
            end else if (update_i) begin
                if (error_q != 2'd0) begin
                    // Ignored until the debugger clears the error.
                end else if (state_q != Idle) begin
                    error_d = 2'd3;
                end else if (dr_q[1:0] == 2'd1 || dr_q[1:0] == 2'd2) begin
                    addr_d  = dr_q[DrWidth-1 -: AddrWidth];
                    data_d  = dr_q[33:2];
                    op_d    = dr_q[1:0];
                    state_d = Req;
                end
            end
        end
    end

    // State register, synchronous active-low reset.
    always_ff @(posedge tck_i) begin
        if (!trst_ni) begin
            state_q <= Idle;
            dtmcs_q <= '0;
            dr_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            op_q    <= '0;
            error_q <= '0;
`ifdef DMI_HARDRESET_EN
            clear_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            dtmcs_q <= dtmcs_d;
            dr_q    <= dr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            op_q    <= op_d;
            error_q <= error_d;
`ifdef DMI_HARDRESET_EN
            clear_q <= clear_d;
`endif
        end
    end

endmodule

// File: tb/tb_dmi_jtag_dr.sv
// tb_dmi_jtag_dr: self-checking bench for dmi_jtag_dr (default parameters).
// The bench plays both the JTAG TAP (scans) and the debug module (a word
// memory answering requests), and predicts captured register contents from
// a transaction-level model of the debug transport.
module tb_dmi_jtag_dr;

    logic        tck = 1'b0;
    logic        trst_ni = 1'b0;
    logic        capture = 1'b0;
    logic        shift = 1'b0;
    logic        update = 1'b0;
    logic        tdi = 1'b0;
    logic        dtmcs_select = 1'b0;
    logic        dtmcs_tdo;
    logic        dmi_select = 1'b0;
    logic        dmi_tdo;
    logic        req_valid;
    logic        req_ready = 1'b1;
    logic [6:0]  req_addr;
    logic [1:0]  req_op;
    logic [31:0] req_data;
    logic        resp_valid = 1'b0;
    logic        resp_ready;
    logic [31:0] resp_data = '0;
    logic [1:0]  resp_resp = '0;
    logic        dmi_clear;

    int total = 0;
    int bad = 0;

    // Transaction-level model: last DMI address/data seen by the debugger,
    // sticky error, and the debug module's register contents.
    logic [6:0]  m_addr = '0;
    logic [31:0] m_data = '0;
    logic [1:0]  m_err = '0;
    logic [31:0] mem [128];

    localparam logic [31:0] DtmcsBase = 32'h0000_1071;

    dmi_jtag_dr dut (
        .tck_i            (tck),
        .trst_ni          (trst_ni),
        .capture_i        (capture),
        .shift_i          (shift),
        .update_i         (update),
        .tdi_i            (tdi),
        .dtmcs_select_i   (dtmcs_select),
        .dtmcs_tdo_o      (dtmcs_tdo),
        .dmi_select_i     (dmi_select),
        .dmi_tdo_o        (dmi_tdo),
        .dmi_req_valid_o  (req_valid),
        .dmi_req_ready_i  (req_ready),
        .dmi_req_addr_o   (req_addr),
        .dmi_req_op_o     (req_op),
        .dmi_req_data_o   (req_data),
        .dmi_resp_valid_i (resp_valid),
        .dmi_resp_ready_o (resp_ready),
        .dmi_resp_data_i  (resp_data),
        .dmi_resp_resp_i  (resp_resp),
        .dmi_clear_o      (dmi_clear)
    );

    always #5 tck = ~tck;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge tck);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One TCK cycle with the given TAP strobes, then strobes return low.
    task automatic applyStimulus(input logic cap, input logic sh, input logic upd, input logic din);
        capture = cap;
        shift   = sh;
        update  = upd;
        tdi     = din;
        tick();
        capture = 1'b0;
        shift   = 1'b0;
        update  = 1'b0;
        tdi     = 1'b0;
    endtask

    task automatic dtmcsScan(input logic [31:0] din, input bit do_update, output logic [31:0] dout);
        dtmcs_select = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 32; i++) begin
            dout[i] = dtmcs_tdo;
            applyStimulus(1'b0, 1'b1, 1'b0, din[i]);
        end
        if (do_update) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        dtmcs_select = 1'b0;
    endtask

    task automatic dmiScan(input logic [40:0] din, input bit do_update, output logic [40:0] dout);
        dmi_select = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 41; i++) begin
            dout[i] = dmi_tdo;
            applyStimulus(1'b0, 1'b1, 1'b0, din[i]);
        end
        if (do_update) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        dmi_select = 1'b0;
    endtask

    task automatic respondDm(input logic [31:0] data, input logic [1:0] resp);
        resp_valid = 1'b1;
        resp_data  = data;
        resp_resp  = resp;
        tick();
        resp_valid = 1'b0;
        resp_data  = '0;
        resp_resp  = '0;
    endtask

    task automatic dmireset();
        logic [31:0] dout;
        dtmcsScan(32'h0001_0000, 1'b1, dout);
        m_err = 2'd0;
    endtask

    // Full DMI transaction from the Idle state with ready held high: scan
    // (checking the previous capture), request, lat wait cycles, response.
    task automatic doTxn(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op,
                         input logic [31:0] rdata, input logic [1:0] resp, input int lat);
        logic [40:0] dout;
        dmiScan({a, d, op}, 1'b1, dout);
        checkOutput("capture", 64'(dout), 64'({m_addr, m_data, m_err}));
        if (m_err != 2'd0 || op == 2'd0 || op == 2'd3) begin
            checkOutput("no_req_valid", 64'(req_valid), 64'd0);
            tick();
            checkOutput("no_req_resp_ready", 64'(resp_ready), 64'd0);
            return;
        end
        checkOutput("req_valid", 64'(req_valid), 64'd1);
        checkOutput("req_addr", 64'(req_addr), 64'(a));
        checkOutput("req_op", 64'(req_op), 64'(op));
        checkOutput("req_data", 64'(req_data), 64'(d));
        tick();
        checkOutput("req_valid_drop", 64'(req_valid), 64'd0);
        checkOutput("resp_ready", 64'(resp_ready), 64'd1);
        repeat (lat) tick();
        checkOutput("resp_ready_hold", 64'(resp_ready), 64'd1);
        respondDm(rdata, resp);
        checkOutput("resp_ready_drop", 64'(resp_ready), 64'd0);
        m_addr = a;
        m_data = (op == 2'd1) ? rdata : d;
        if (resp != 2'd0) m_err = (resp == 2'd1) ? 2'd2 : resp;
        if (op == 2'd2) mem[a] = d;
    endtask

    initial begin
        logic [31:0] d32;
        logic [40:0] d41;
        logic [1:0]  rr;
        logic [6:0]  ra;
        logic [31:0] rd;
        logic [1:0]  rop;

        for (int i = 0; i < 128; i++) mem[i] = $urandom;

        // Reset
        repeat (3) tick();
        checkOutput("rst_req_valid", 64'(req_valid), 64'd0);
        checkOutput("rst_resp_ready", 64'(resp_ready), 64'd0);
        checkOutput("rst_outputs", 64'({req_addr, req_op, req_data, dmi_clear, dtmcs_tdo, dmi_tdo}), 64'd0);
        trst_ni = 1'b1;
        tick();

        // DTMCS identification
        dtmcsScan(32'h0, 1'b0, d32);
        checkOutput("dtmcs_capture", 64'(d32), 64'(DtmcsBase));

        // Directed write then read
        doTxn(7'h10, 32'hDEAD_BEEF, 2'd2, 32'h0, 2'd0, 0);
        doTxn(7'h11, 32'h0, 2'd1, 32'hCAFE_F00D, 2'd0, 2);
        doTxn(7'h12, 32'h0, 2'd0, 32'h0, 2'd0, 0);

        // Busy: scan while the response is withheld
        dmiScan({7'h20, 32'h1234_5678, 2'd2}, 1'b1, d41);
        checkOutput("busy_first_capture", 64'(d41), 64'({m_addr, m_data, m_err}));
        checkOutput("busy_req_valid", 64'(req_valid), 64'd1);
        tick();
        dmiScan({7'h21, 32'h5555_AAAA, 2'd2}, 1'b1, d41);
        checkOutput("busy_capture_op", 64'(d41), 64'({7'h20, 32'h1234_5678, 2'd3}));
        checkOutput("busy_update_ignored", 64'(req_valid), 64'd0);
        checkOutput("busy_still_waiting", 64'(resp_ready), 64'd1);
        respondDm(32'h0, 2'd0);
        m_addr = 7'h20;
        m_data = 32'h1234_5678;
        m_err  = 2'd3;
        mem[7'h20] = 32'h1234_5678;
        doTxn(7'h22, 32'h0BAD_CAFE, 2'd2, 32'h0, 2'd0, 0);
        dtmcsScan(32'h0001_0000, 1'b1, d32);
        checkOutput("dtmcs_busy_stat", 64'(d32), 64'(DtmcsBase | 32'h0000_0C00));
        m_err = 2'd0;
        dtmcsScan(32'h0, 1'b0, d32);
        checkOutput("dtmcs_after_dmireset", 64'(d32), 64'(DtmcsBase));
        doTxn(7'h23, 32'hAAAA_5555, 2'd2, 32'h0, 2'd0, 1);

        // Error responses, including the reserved code 1
        for (int r = 1; r < 4; r++) begin
            rr = 2'(r);
            doTxn(7'h30, 32'h0, 2'd1, 32'h0BAD_0BAD, rr, 0);
            dtmcsScan(32'h0, 1'b0, d32);
            checkOutput("dtmcs_err_stat", 64'(d32), 64'(DtmcsBase | (32'(m_err) << 10)));
            doTxn(7'h31, 32'h1111_2222, 2'd2, 32'h0, 2'd0, 0);
            dmireset();
        end

        // Hard reset request while a request is pending
        req_ready = 1'b0;
        dmiScan({7'h40, 32'hFEED_FACE, 2'd2}, 1'b1, d41);
        checkOutput("hr_capture", 64'(d41), 64'({m_addr, m_data, m_err}));
        repeat (3) tick();
        checkOutput("hr_req_held_valid", 64'(req_valid), 64'd1);
        checkOutput("hr_req_held_addr", 64'(req_addr), 64'h40);
        dtmcsScan(32'h0002_0000, 1'b1, d32);
        checkOutput("hr_dtmcs_capture", 64'(d32), 64'(DtmcsBase));
`ifdef DMI_HARDRESET_EN
        checkOutput("hr_clear_pulse", 64'(dmi_clear), 64'd1);
        checkOutput("hr_valid_drop", 64'(req_valid), 64'd0);
        tick();
        checkOutput("hr_clear_end", 64'(dmi_clear), 64'd0);
        checkOutput("hr_idle", 64'({req_valid, resp_ready}), 64'd0);
        req_ready = 1'b1;
        m_addr = '0;
        m_data = '0;
        m_err  = '0;
`else
        checkOutput("hr_clear_tied", 64'(dmi_clear), 64'd0);
        checkOutput("hr_ignored_valid", 64'(req_valid), 64'd1);
        req_ready = 1'b1;
        tick();
        checkOutput("hr_ignored_wait", 64'(resp_ready), 64'd1);
        respondDm(32'h0, 2'd0);
        m_addr = 7'h40;
        m_data = 32'hFEED_FACE;
        mem[7'h40] = 32'hFEED_FACE;
`endif

        // Random reads and writes against the memory model
        for (int n = 0; n < 12; n++) begin
            ra  = 7'($urandom_range(0, 127));
            rd  = $urandom;
            rop = 2'($urandom_range(1, 2));
            doTxn(ra, rd, rop, (rop == 2'd1) ? mem[ra] : $urandom, 2'd0, $urandom_range(0, 3));
        end
        doTxn(7'h00, 32'h0, 2'd0, 32'h0, 2'd0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
